// File: rtl/adder_subtractor_16_if.sv
// Operand/result bundle for the 16-bit add/sub slice.
// The master drives the operands and mode. The slave returns the registered result.
interface adder_subtractor_16_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        M;
  logic [15:0] sum;
  logic        c_out;

  modport master (output a, output b, output M, input sum, input c_out);
  modport slave  (input a, input b, input M, output sum, output c_out);
endinterface

// File: rtl/adder_subtractor_16.sv
// Registered 16-bit two's-complement adder/subtractor built from four 4-bit ripple groups.
// In subtract mode (M=1), c_out is the raw carry, so 1 means no borrow occurred.
module adder_subtractor_16 (
  input  logic                 clk,
  input  logic                 rst_n,
  adder_subtractor_16_if.slave bus
);

  logic [15:0] b_eff;
  logic [15:0] s;
  logic [4:0]  group_c;
  logic [16:0] c;

  assign b_eff = bus.b ^ {16{bus.M}};

  // Each group ripples internally; its carry-out feeds the next group's carry-in.
  always_comb begin
    s          = '0;
    c          = '0;
    group_c    = '0;
    group_c[0] = bus.M;
    for (int unsigned g = 0; g < 4; g++) begin
      c[4*g] = group_c[g];
      for (int unsigned k = 0; k < 4; k++) begin
        s[4*g+k]   = bus.a[4*g+k] ^ b_eff[4*g+k] ^ c[4*g+k];
        c[4*g+k+1] = (bus.a[4*g+k] & b_eff[4*g+k])
                   | (c[4*g+k] & (bus.a[4*g+k] ^ b_eff[4*g+k]));
      end
      group_c[g+1] = c[4*g+4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum   <= '0;
      bus.c_out <= 1'b0;
    end else begin
      bus.sum   <= s;
      bus.c_out <= group_c[4];
    end
  end

endmodule

// File: tb/tb_adder_subtractor_16.sv
// Directed-vector bench for adder_subtractor_16 with hand-computed expected results.
module tb_adder_subtractor_16;

  logic clk;
  logic rst_n;
  int unsigned n_checks;
  int unsigned n_errors;

  adder_subtractor_16_if bus ();

  adder_subtractor_16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got c_out=%b sum=%h, required c_out=%b sum=%h",
               tag, obs[16], obs[15:0], exp[16], exp[15:0]);
    end
  endtask

  // Present operands, clock once, then check the registered result 1ns after the edge.
  task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic m, input logic [15:0] s, input logic c);
    bus.a = a;
    bus.b = b;
    bus.M = m;
    @(posedge clk);
    #1;
    check(tag, {bus.c_out, bus.sum}, {c, s});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    bus.M = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", {bus.c_out, bus.sum}, 17'h0_0000);
    @(negedge clk);
    check("reset_hold_neg", {bus.c_out, bus.sum}, 17'h0_0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", {bus.c_out, bus.sum}, 17'h1_0000);

    run_vec("add_5_6", 16'd5, 16'd6, 1'b0, 16'd11, 1'b0);
    run_vec("add_5_7", 16'd5, 16'd7, 1'b0, 16'd12, 1'b0);
    run_vec("add_5_8", 16'd5, 16'd8, 1'b0, 16'd13, 1'b0);
    run_vec("add_6_6", 16'd6, 16'd6, 1'b0, 16'd12, 1'b0);
    run_vec("add_6_7", 16'd6, 16'd7, 1'b0, 16'd13, 1'b0);
    run_vec("add_6_8", 16'd6, 16'd8, 1'b0, 16'd14, 1'b0);
    run_vec("add_7_6", 16'd7, 16'd6, 1'b0, 16'd13, 1'b0);
    run_vec("add_7_7", 16'd7, 16'd7, 1'b0, 16'd14, 1'b0);
    run_vec("add_7_8", 16'd7, 16'd8, 1'b0, 16'd15, 1'b0);

    run_vec("sub_6_0", 16'd6, 16'd0, 1'b1, 16'd6, 1'b1);
    run_vec("sub_6_1", 16'd6, 16'd1, 1'b1, 16'd5, 1'b1);
    run_vec("sub_6_2", 16'd6, 16'd2, 1'b1, 16'd4, 1'b1);
    run_vec("sub_6_3", 16'd6, 16'd3, 1'b1, 16'd3, 1'b1);
    run_vec("sub_6_4", 16'd6, 16'd4, 1'b1, 16'd2, 1'b1);
    run_vec("sub_7_0", 16'd7, 16'd0, 1'b1, 16'd7, 1'b1);
    run_vec("sub_7_1", 16'd7, 16'd1, 1'b1, 16'd6, 1'b1);
    run_vec("sub_7_2", 16'd7, 16'd2, 1'b1, 16'd5, 1'b1);
    run_vec("sub_7_3", 16'd7, 16'd3, 1'b1, 16'd4, 1'b1);
    run_vec("sub_7_4", 16'd7, 16'd4, 1'b1, 16'd3, 1'b1);

    run_vec("borrow_3_5",   16'd3,    16'd5,    1'b1, 16'hFFFE, 1'b0);
    run_vec("wrap_ffff_2",  16'hFFFF, 16'd2,    1'b0, 16'h0001, 1'b1);
    run_vec("group_0fff_1", 16'h0FFF, 16'd1,    1'b0, 16'h1000, 1'b0);
    run_vec("sub_8000_8000",16'h8000, 16'h8000, 1'b1, 16'h0000, 1'b1);
    run_vec("sub_equal",    16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1);
    run_vec("sub_0_1",      16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0);
    run_vec("add_ffff_ffff",16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1);
    run_vec("add_a5a5_5a5a",16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0);
    run_vec("add_00ff_0001",16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0);
    run_vec("add_fff0_0010",16'hFFF0, 16'h0010, 1'b0, 16'h0000, 1'b1);

    // Mode switch back-to-back. The output must hold until the next edge.
    bus.a = 16'd10;
    bus.b = 16'd3;
    bus.M = 1'b0;
    #2;
    check("hold_before_edge", {bus.c_out, bus.sum}, 17'h1_0000);
    @(posedge clk);
    #1;
    check("b2b_add", {bus.c_out, bus.sum}, {1'b0, 16'd13});
    bus.M = 1'b1;
    @(posedge clk);
    #1;
    check("b2b_sub", {bus.c_out, bus.sum}, {1'b1, 16'd7});

    // Asynchronous reset pulse between clock edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {bus.c_out, bus.sum}, 17'h0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    check("async_reset_hold", {bus.c_out, bus.sum}, 17'h0_0000);
    run_vec("after_reset", 16'd10, 16'd3, 1'b1, 16'd7, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
